// File: rtl/inst_encoder.sv
// TinyRV1 instruction encoder: two register stages with valid/ready on both sides.
// S1 registers the request, its immediate class and range error; S2 holds the packed word.
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_op,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [31:0]      resp_inst,
  output logic             resp_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_MUL  = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_JAL  = 3'd5,
    OP_JR   = 3'd6,
    OP_BNE  = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    IT_NONE,
    IT_I,
    IT_S,
    IT_B,
    IT_J
  } imm_t;

  op_t         req_opc;
  imm_t        req_cls;
  logic        req_err;
  logic        fit12;
  logic        fit13;
  logic        fit21;

  logic        s1_val;
  op_t         s1_op;
  imm_t        s1_cls;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic        s1_err;

  logic        s2_val;
  logic [31:0] s2_inst;
  logic        s2_err;

  logic [31:0] pack;
  logic        s1_adv;
  logic        s2_adv;
  logic [CNT_W-1:0] cnt;

  assign req_opc = op_t'(req_op);

  assign s2_adv  = !s2_val | resp_rdy;
  assign s1_adv  = !s1_val | s2_adv;
  assign req_rdy = s1_adv;

  // Sign-extension checks: upper bits all equal to the top kept bit.
  assign fit12 = (req_imm[31:11] == '0) | (req_imm[31:11] == '1);
  assign fit13 = (req_imm[31:12] == '0) | (req_imm[31:12] == '1);
  assign fit21 = (req_imm[31:20] == '0) | (req_imm[31:20] == '1);

  always_comb begin
    req_cls = IT_NONE;
    unique case (req_opc)
      OP_ADD, OP_MUL, OP_JR: req_cls = IT_NONE;
      OP_ADDI, OP_LW:        req_cls = IT_I;
      OP_SW:                 req_cls = IT_S;
      OP_BNE:                req_cls = IT_B;
      OP_JAL:                req_cls = IT_J;
      default:               req_cls = IT_NONE;
    endcase
  end

  always_comb begin
    req_err = 1'b0;
    unique case (req_cls)
      IT_I, IT_S: req_err = !fit12;
      IT_B:       req_err = !fit13 | req_imm[0];
      IT_J:       req_err = !fit21 | req_imm[0];
      default:    req_err = 1'b0;
    endcase
  end

  always_comb begin
    pack = '0;
    unique case (s1_op)
      OP_ADD:  pack = {7'b0000000, s1_rs2, s1_rs1, 3'b000,
                       s1_rd, 7'b0110011};
      OP_MUL:  pack = {7'b0000001, s1_rs2, s1_rs1, 3'b000,
                       s1_rd, 7'b0110011};
      OP_ADDI: pack = {s1_imm[11:0], s1_rs1, 3'b000,
                       s1_rd, 7'b0010011};
      OP_LW:   pack = {s1_imm[11:0], s1_rs1, 3'b010,
                       s1_rd, 7'b0000011};
      OP_SW:   pack = {s1_imm[11:5], s1_rs2, s1_rs1, 3'b010,
                       s1_imm[4:0], 7'b0100011};
      OP_JAL:  pack = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                       s1_imm[19:12], s1_rd, 7'b1101111};
      OP_JR:   pack = {12'b0, s1_rs1, 3'b000,
                       5'b00000, 7'b1100111};
      OP_BNE:  pack = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1,
                       3'b001, s1_imm[4:1], s1_imm[11], 7'b1100011};
      default: pack = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val <= 1'b0;
      s1_op  <= OP_ADD;
      s1_cls <= IT_NONE;
      s1_rd  <= '0;
      s1_rs1 <= '0;
      s1_rs2 <= '0;
      s1_imm <= '0;
      s1_err <= 1'b0;
    end else if (s1_adv) begin
      s1_val <= req_val;
      if (req_val) begin
        s1_op  <= req_opc;
        s1_cls <= req_cls;
        s1_rd  <= req_rd;
        s1_rs1 <= req_rs1;
        s1_rs2 <= req_rs2;
        s1_imm <= req_imm;
        s1_err <= req_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_val  <= 1'b0;
      s2_inst <= '0;
      s2_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_val <= s1_val;
      if (s1_val) begin
        s2_inst <= pack;
        s2_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2_val && resp_rdy && s2_err && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign resp_val  = s2_val;
  assign resp_inst = s2_inst;
  assign resp_err  = s2_err;
  assign err_count = cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors plus randomized traffic
// scored against an arithmetic encoding model and an immediate decoder.
module tb_inst_encoder;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_val;
  logic          req_rdy;
  logic [2:0]    req_op;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [31:0]   req_imm;
  logic          resp_val;
  logic          resp_rdy;
  logic [31:0]   resp_inst;
  logic          resp_err;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  inst_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_inst (resp_inst),
    .resp_err  (resp_err),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          op;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          mcnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_inst = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic longint unsigned fld(logic [31:0] v, int hi, int lo);
    longint unsigned u;
    u = {32'b0, v};
    return (u >> lo) & ((64'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] ref_enc(int op, int rd, int rs1,
                                          int rs2, logic [31:0] imm);
    longint unsigned r, pr, p1, p2;
    pr = longint'(rd) * 128;
    p1 = longint'(rs1) * 32768;
    p2 = longint'(rs2) * (64'd1 << 20);
    case (op)
      0: r = 64'h33 + pr + p1 + p2;
      1: r = 64'h13 + pr + p1 + fld(imm, 11, 0) * (64'd1 << 20);
      2: r = 64'h33 + pr + p1 + p2 + (64'd1 << 25);
      3: r = 64'h03 + pr + 2 * 4096 + p1
             + fld(imm, 11, 0) * (64'd1 << 20);
      4: r = 64'h23 + fld(imm, 4, 0) * 128 + 2 * 4096 + p1 + p2
             + fld(imm, 11, 5) * (64'd1 << 25);
      5: r = 64'h6F + pr + fld(imm, 19, 12) * 4096
             + fld(imm, 11, 11) * (64'd1 << 20)
             + fld(imm, 10, 1) * (64'd1 << 21)
             + fld(imm, 20, 20) * (64'd1 << 31);
      6: r = 64'h67 + p1;
      default: r = 64'h63 + fld(imm, 11, 11) * 128
             + fld(imm, 4, 1) * 256 + 4096 + p1 + p2
             + fld(imm, 10, 5) * (64'd1 << 25)
             + fld(imm, 12, 12) * (64'd1 << 31);
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_err(int op, logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (op)
      1, 3, 4: return (v < -2048) || (v > 2047);
      7: return (v < -4096) || (v > 4094) || (v % 2 != 0);
      5: return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int dec_imm(int op, logic [31:0] inst);
    logic signed [31:0] s;
    s = inst;
    case (op)
      1, 3: return int'(s >>> 20);
      4: return int'(s >>> 25) * 32 + int'(inst[11:7]);
      7: return (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
             + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      5: return (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096
             + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (resp_val && resp_rdy) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          chk("inst", resp_inst, me.inst);
          chk("err", {31'b0, resp_err}, {31'b0, me.err});
          if (!me.err && (me.op inside {1, 3, 4, 5, 7}))
            chk("roundtrip", dec_imm(me.op, resp_inst), me.imm);
          if (me.err && mcnt < (1 << CW) - 1) mcnt++;
        end
      end
      if (held_v && resp_val) chk("stall_hold", resp_inst, held_inst);
      held_v    <= resp_val && !resp_rdy;
      held_inst <= resp_inst;
      if (req_val && req_rdy) begin
        me.op   = int'(req_op);
        me.imm  = req_imm;
        me.inst = ref_enc(req_op, req_rd, req_rs1, req_rs2, req_imm);
        me.err  = ref_err(req_op, req_imm);
        q.push_back(me);
      end
    end
  end

  task automatic set_req(int op, int rd, int rs1, int rs2,
                         logic [31:0] imm);
    req_op  = op[2:0];
    req_rd  = rd[4:0];
    req_rs1 = rs1[4:0];
    req_rs2 = rs2[4:0];
    req_imm = imm;
  endtask

  task automatic send(int op, int rd, int rs1, int rs2, logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    set_req(op, rd, rs1, rs2, imm);
    req_val = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = req_rdy;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    req_val = 1'b0;
  endtask

  task automatic expect_resp(string tag, logic [31:0] inst, logic err);
    int n;
    n = 0;
    while (!resp_val && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_val"}, {31'b0, resp_val}, 32'd1);
    chk(tag, resp_inst, inst);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, err});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    int bl[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                   -4098, 1048574, 1048575, 1048576, -1048576,
                   -1048578, 0, 1};
    int sel;
    logic [31:0] imm;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: imm = $urandom;
      1: imm = $urandom_range(0, 64) - 32;
      2: imm = bl[$urandom_range(0, 15)];
      default: imm = $urandom_range(0, 10000) - 5000;
    endcase
    set_req($urandom_range(0, 7), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit a;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    set_req(0, 0, 0, 0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", {31'b0, resp_val}, 32'd0);
    chk("rst_inst", resp_inst, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_cnt", {30'b0, err_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(1, 1, 2, 0, -1);
    chk("lat_n", {31'b0, resp_val}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n1", {31'b0, resp_val}, 32'd1);
    expect_resp("addi", 32'hFFF10093, 1'b0);
    send(4, 9, 4, 3, 8);
    expect_resp("sw", 32'h00322423, 1'b0);
    send(7, 5, 1, 0, -4);
    expect_resp("bne", 32'hFE009EE3, 1'b0);
    send(5, 1, 7, 9, 2048);
    expect_resp("jal", 32'h001000EF, 1'b0);
    send(6, 5, 3, 7, 100);
    expect_resp("jr", 32'h00018067, 1'b0);
    chk("cnt0", {30'b0, err_count}, 32'd0);
    send(1, 1, 2, 0, 2048);
    expect_resp("addi_ovf", 32'h80010093, 1'b1);
    chk("cnt1", {30'b0, err_count}, 32'd1);
    send(7, 0, 1, 0, 6);
    expect_resp("bne6", ref_enc(7, 0, 1, 0, 6), ref_err(7, 6));
    send(7, 0, 1, 0, 3);
    expect_resp("bne3", ref_enc(7, 0, 1, 0, 3), 1'b1);
    send(5, 2, 0, 0, 1048574);
    expect_resp("jal_max", ref_enc(5, 2, 0, 0, 1048574), 1'b0);

    for (int i = 0; i < 8; i++) begin
      set_req(i, i + 1, i + 2, i + 3, i * 4);
      req_val = 1'b1;
      chk("stream_rdy", {31'b0, req_rdy}, 32'd1);
      @(posedge clk);
      #1;
      if (i >= 1) chk("stream_cont", {31'b0, resp_val}, 32'd1);
    end
    req_val = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_last", {31'b0, resp_val}, 32'd1);
    repeat (4) @(posedge clk);
    #1;

    resp_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(1, acc + 3, 4, 0, acc * 16 + 1);
      req_val = 1'b1;
      a = req_rdy;
      @(posedge clk);
      #1;
      if (a) acc++;
    end
    chk("bp_accepts", acc, 32'd2);
    chk("bp_rdy_low", {31'b0, req_rdy}, 32'd0);
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drain", q.size(), 32'd0);

    resp_rdy = 1'b0;
    send(1, 1, 1, 0, 2048);
    send(4, 0, 2, 3, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_val", {31'b0, resp_val}, 32'd0);
    chk("arst_cnt", {30'b0, err_count}, 32'd0);
    chk("arst_rdy", {31'b0, req_rdy}, 32'd1);
    q.delete();
    mcnt   = 0;
    held_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_rdy = 1'b1;
    send(1, 3, 4, 0, 5);
    expect_resp("post_rst", 32'h00520193, 1'b0);

    for (int i = 0; i < 4; i++) begin
      send(1, 1, 2, 0, 4096);
      expect_resp("sat_resp", ref_enc(1, 1, 2, 0, 4096), 1'b1);
      chk("sat_cnt", {30'b0, err_count}, (i + 1 > 3) ? 3 : i + 1);
    end

    for (int i = 0; i < 400; i++) begin
      rand_req();
      req_val  = ($urandom_range(0, 3) != 0);
      resp_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("final_drain", q.size(), 32'd0);
    chk("final_cnt", {30'b0, err_count}, mcnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
